psddiv_arbiter: RTL

PSDDIV_ARBITER -- requirements
Module: psddiv_arbiter

---
 rtl/psddiv_pkg.sv | 19 +
 rtl/psddiv_rr_pick.sv | 28 ++
 rtl/psddiv_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/psddiv_pkg.sv
// psddiv_pkg: operand widths, arbiter FSM state type and the saturation
// values returned for a zero divisor when the bypass option is built in.
package psddiv_pkg;

    localparam int DIVIDEND_W = 32;
    localparam int DIVISOR_W  = 16;

    localparam logic [DIVIDEND_W-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [DIVIDEND_W-1:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

endpackage

// File: rtl/psddiv_rr_pick.sv
// psddiv_rr_pick: combinational round-robin pick. Scans upward from the
// requester after last_grant, wrapping NREQ-1 -> 0; first pending bit wins.
module psddiv_rr_pick #(
    parameter int NREQ = 2,
    parameter int GW   = 1
) (
    input  logic [NREQ-1:0] pending,
    input  logic [GW-1:0]   last_grant,
    output logic [GW-1:0]   grant,
    output logic            valid
);

    // Walk the NREQ positions after last_grant; last_grant itself is checked last
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!valid && pending[idx]) begin
                valid = 1'b1;
                grant = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/psddiv_arbiter.sv
// psddiv_arbiter: shares one psddivide_top divider between NREQ requesters.
// Each requester owns a holding register; a round-robin FSM issues one
// division at a time and returns the result on a shared bus with req_done.
// Build option: PSDDIV_DIVZ_BYPASS_EN answers zero-divisor requests locally
// with a saturated quotient instead of sending them to the divider.
module psddiv_arbiter
    import psddiv_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_run,
    input  logic [NREQ*DIVIDEND_W-1:0] req_dividend,
    input  logic [NREQ*DIVISOR_W-1:0]  req_divisor,
    output logic [NREQ-1:0]            req_busy,
    output logic [NREQ-1:0]            req_done,
    output logic [DIVIDEND_W-1:0]      quotient,
    output logic [DIVISOR_W-1:0]       rest,
    output logic                       divz,
    output logic                       div_run,
    input  logic                       div_busy,
    output logic [DIVIDEND_W-1:0]      div_dividend,
    output logic [DIVISOR_W-1:0]       div_divisor,
    input  logic [DIVIDEND_W-1:0]      div_quotient,
    input  logic [DIVISOR_W-1:0]       div_rest
);

    localparam int            GW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

    state_t                state, state_nxt;
    logic [NREQ-1:0]       pending;
    logic [DIVIDEND_W-1:0] hold_dividend [NREQ];
    logic [DIVISOR_W-1:0]  hold_divisor  [NREQ];
    logic [GW-1:0]         last_grant, grant, pick;
    logic                  pick_valid;
    logic                  start;
    logic                  bypass;

    psddiv_rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
        .pending    (pending),
        .last_grant (last_grant),
        .grant      (pick),
        .valid      (pick_valid)
    );

`ifdef PSDDIV_DIVZ_BYPASS_EN
    assign bypass = (hold_divisor[pick] == '0);
`else
    assign bypass = 1'b0;
`endif

    assign req_busy = pending;
    assign div_run  = (state == ISSUE);
    assign req_done = (state == DONE) ? (NREQ'(1) << grant) : '0;

    // Capture operands of accepted requests; ignored while the requester is busy
    always_ff @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (req_run[i] && !pending[i]) begin
                hold_dividend[i] <= req_dividend[i*DIVIDEND_W +: DIVIDEND_W];
                hold_divisor[i]  <= req_divisor[i*DIVISOR_W +: DIVISOR_W];
            end
        end
    end

    // Pending bits set on acceptance, cleared and rotated when service completes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending    <= '0;
            last_grant <= LAST_INIT;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_run[i] && !pending[i]) pending[i] <= 1'b1;
            end
            if (state == DONE) begin
                pending[grant] <= 1'b0;
                last_grant     <= grant;
            end
        end
    end

    // FSM state and the granted requester
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
        end else begin
            state <= state_nxt;
            if (start) grant <= pick;
        end
    end

    // Next state; a grant also waits for a divider left busy by an earlier reset
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid && !div_busy) begin
                    start     = 1'b1;
                    state_nxt = bypass ? DONE : ISSUE;
                end
            end
            ISSUE:   state_nxt = WAIT_HI;
            WAIT_HI: if (div_busy)  state_nxt = WAIT_LO;
            WAIT_LO: if (!div_busy) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Divider operands held from grant to the next grant; results captured as DONE begins
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            quotient     <= '0;
            rest         <= '0;
        end else begin
            if (start) begin
                div_dividend <= hold_dividend[pick];
                div_divisor  <= hold_divisor[pick];
            end
            if (state == WAIT_LO && !div_busy) begin
                quotient <= div_quotient;
                rest     <= div_rest;
            end
            if (start && bypass) begin
                quotient <= hold_dividend[pick][DIVIDEND_W-1] ? SAT_NEG : SAT_POS;
                rest     <= '0;
            end
        end
    end

`ifdef PSDDIV_DIVZ_BYPASS_EN
    // Zero-divisor flag follows each service, set only for bypassed requests
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) divz <= 1'b0;
        else if (start) divz <= bypass;
    end
`else
    assign divz = 1'b0;
`endif

endmodule
